// File: rtl/ext_irq_ctrl_pkg.sv
// Shared mode encodings and sizing helper for the external-interrupt controller.
package ext_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_LVL  = 2'b11
  } irq_mode_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_irq_ctrl_if.sv
// Channel-side bundle of the interrupt controller: inputs, pending view and core request.
interface ext_irq_ctrl_if #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
);
  logic              en;
  logic [N_CH-1:0]   sync_in;
  logic [2*N_CH-1:0] mode_i;
  logic [N_CH-1:0]   mask_i;
  logic [N_CH-1:0]   clr_i;
  logic [N_CH-1:0]   pend_o;
  logic              irq_o;
  logic [ID_W-1:0]   irq_id_o;
  logic [N_CH-1:0]   ovf_o;

  modport master (
    output en, sync_in, mode_i, mask_i, clr_i,
    input  pend_o, irq_o, irq_id_o, ovf_o
  );

  modport slave (
    input  en, sync_in, mode_i, mask_i, clr_i,
    output pend_o, irq_o, irq_id_o, ovf_o
  );
endinterface

// File: rtl/ext_irq_chan.sv
// One interrupt channel: glitch filter, mode-selectable detector, pending bit.
// Overflow tracking is built only when EXT_IRQ_OVF_EN is defined.
module ext_irq_chan
  import ext_irq_ctrl_pkg::*;
#(
  parameter int FILT_CYCLES = 3
) (
  input  logic       s_clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sync_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       pend,
  output logic       ovf
);
  localparam int CNT_W = $clog2(FILT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             filt_lvl, filt_lvl_d;
  logic             rise, fall, evt_raw, evt;

  always_ff @(posedge s_clk) begin
    if (rst) begin
      cnt        <= '0;
      filt_lvl   <= 1'b0;
      filt_lvl_d <= 1'b0;
    end else if (en) begin
      filt_lvl_d <= filt_lvl;
      if (sync_in != filt_lvl) begin
        if (cnt == CNT_W'(FILT_CYCLES - 1)) begin
          filt_lvl <= sync_in;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = filt_lvl & ~filt_lvl_d;
  assign fall = ~filt_lvl & filt_lvl_d;

  always_comb begin
    evt_raw = 1'b0;
    case (irq_mode_e'(mode))
      MODE_RISE: evt_raw = rise;
      MODE_FALL: evt_raw = fall;
      MODE_BOTH: evt_raw = rise | fall;
      MODE_LVL:  evt_raw = filt_lvl;
      default:   evt_raw = 1'b0;
    endcase
  end

  // Frozen detector state must not keep firing level events while disabled.
  assign evt = en & evt_raw;

  always_ff @(posedge s_clk) begin
    if (rst)      pend <= 1'b0;
    else if (evt) pend <= 1'b1;
    else if (clr) pend <= 1'b0;
  end

`ifdef EXT_IRQ_OVF_EN
  always_ff @(posedge s_clk) begin
    if (rst)              ovf <= 1'b0;
    else if (clr)         ovf <= 1'b0;
    else if (evt && pend) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ext_irq_ctrl.sv
// Multi-channel external-interrupt controller: per-channel filter/detect/pend,
// lowest-index priority encoder and registered request. Optional: EXT_IRQ_OVF_EN.
module ext_irq_ctrl
  import ext_irq_ctrl_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int FILT_CYCLES = 3,
  parameter int ID_W        = id_width(N_CH)
) (
  input logic          s_clk,
  input logic          rst,
  ext_irq_ctrl_if.slave bus
);
  logic [N_CH-1:0] pend, ovf, act;
  logic            hit;
  logic [ID_W-1:0] id_nxt;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ext_irq_chan #(.FILT_CYCLES(FILT_CYCLES)) u_chan (
      .s_clk   (s_clk),
      .rst     (rst),
      .en      (bus.en),
      .sync_in (bus.sync_in[k]),
      .mode    (bus.mode_i[2*k+1:2*k]),
      .clr     (bus.clr_i[k]),
      .pend    (pend[k]),
      .ovf     (ovf[k])
    );
  end

  assign act = pend & bus.mask_i;

  // Scan downward so the lowest active index is the last one written.
  always_comb begin
    hit    = 1'b0;
    id_nxt = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (act[k]) begin
        hit    = 1'b1;
        id_nxt = ID_W'(k);
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (rst) begin
      bus.irq_o    <= 1'b0;
      bus.irq_id_o <= '0;
    end else begin
      bus.irq_o    <= hit;
      bus.irq_id_o <= id_nxt;
    end
  end

  assign bus.pend_o = pend;
  assign bus.ovf_o  = ovf;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl (N_CH=4, FILT_CYCLES=3); overflow checks follow EXT_IRQ_OVF_EN.
module tb_ext_irq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef EXT_IRQ_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  ext_irq_ctrl_if #(.N_CH(4), .ID_W(2)) bus ();

  ext_irq_ctrl #(.N_CH(4), .FILT_CYCLES(3), .ID_W(2)) dut (
    .s_clk (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.en      = 1'b1;
    bus.sync_in = '0;
    bus.mode_i  = '0;
    bus.mask_i  = 4'b0001;
    bus.clr_i   = '0;

    // reset
    step(2);
    chk("rst_pend", 32'(bus.pend_o), 0);
    chk("rst_irq", 32'(bus.irq_o), 0);
    chk("rst_id", 32'(bus.irq_id_o), 0);
    chk("rst_ovf", 32'(bus.ovf_o), 0);

    // basic rise latency on ch0
    rst = 1'b0;
    bus.sync_in[0] = 1'b1;
    step(3);
    chk("t1_pend_early", 32'(bus.pend_o), 0);
    step(1);
    chk("t1_pend", 32'(bus.pend_o), 32'b0001);
    chk("t1_irq_early", 32'(bus.irq_o), 0);
    step(1);
    chk("t1_irq", 32'(bus.irq_o), 1);
    chk("t1_id", 32'(bus.irq_id_o), 0);
    bus.clr_i[0] = 1'b1;
    step(1);
    bus.clr_i = '0;
    chk("t1_clr_pend", 32'(bus.pend_o), 0);
    step(1);
    chk("t1_clr_irq", 32'(bus.irq_o), 0);

    // 2-cycle glitch on ch1, both-edge mode
    bus.mode_i = 8'b0000_1000;
    bus.sync_in[1] = 1'b1;
    step(2);
    chk("t2_cnt_mid", 32'(dut.g_ch[1].u_chan.cnt), 2);
    bus.sync_in[1] = 1'b0;
    step(1);
    chk("t2_cnt_zero", 32'(dut.g_ch[1].u_chan.cnt), 0);
    step(3);
    chk("t2_pend1", 32'(bus.pend_o[1]), 0);

    // priority between ch2 and ch3
    bus.mask_i = 4'b1100;
    bus.sync_in[3:2] = 2'b11;
    step(4);
    chk("t3_pend", 32'(bus.pend_o), 32'b1100);
    step(1);
    chk("t3_irq", 32'(bus.irq_o), 1);
    chk("t3_id2", 32'(bus.irq_id_o), 2);
    bus.clr_i[2] = 1'b1;
    step(1);
    bus.clr_i = '0;
    chk("t3_pend_c2", 32'(bus.pend_o), 32'b1000);
    chk("t3_id_hold", 32'(bus.irq_id_o), 2);
    step(1);
    chk("t3_id3", 32'(bus.irq_id_o), 3);
    bus.clr_i[3] = 1'b1;
    step(1);
    bus.clr_i = '0;
    chk("t3_pend_c3", 32'(bus.pend_o), 0);
    step(1);
    chk("t3_irq_off", 32'(bus.irq_o), 0);
    chk("t3_id_off", 32'(bus.irq_id_o), 0);

    // clear coinciding with a new rise on ch0: set wins
    bus.sync_in[0] = 1'b0;
    step(4);
    bus.sync_in[0] = 1'b1;
    step(4);
    chk("t4_pend_first", 32'(bus.pend_o[0]), 1);
    bus.sync_in[0] = 1'b0;
    step(4);
    bus.sync_in[0] = 1'b1;
    step(3);
    bus.clr_i[0] = 1'b1;
    step(1);
    bus.clr_i = '0;
    chk("t4_set_wins", 32'(bus.pend_o[0]), 1);
    chk("t4_ovf0", 32'(bus.ovf_o[0]), 0);
    bus.clr_i[0] = 1'b1;
    step(1);
    bus.clr_i = '0;
    chk("t4_clr", 32'(bus.pend_o[0]), 0);

    // enable low freezes the detector
    bus.sync_in[0] = 1'b0;
    step(4);
    bus.en = 1'b0;
    bus.sync_in[0] = 1'b1;
    step(10);
    chk("t5_frozen", 32'(bus.pend_o[0]), 0);
    bus.en = 1'b1;
    step(3);
    chk("t5_reen_early", 32'(bus.pend_o[0]), 0);
    step(1);
    chk("t5_reen_pend", 32'(bus.pend_o[0]), 1);

    // two rises on ch1 without clear
    bus.mode_i = 8'b0000_0000;
    bus.sync_in[1] = 1'b1;
    step(4);
    chk("t6_pend1", 32'(bus.pend_o[1]), 1);
    chk("t6_ovf_first", 32'(bus.ovf_o[1]), 0);
    bus.sync_in[1] = 1'b0;
    step(4);
    bus.sync_in[1] = 1'b1;
    step(4);
    chk("t6_ovf", 32'(bus.ovf_o[1]), 32'(OVF_EXP));
    bus.clr_i[1] = 1'b1;
    step(1);
    bus.clr_i = '0;
    chk("t6_ovf_clr", 32'(bus.ovf_o[1]), 0);
    chk("t6_pend_clr", 32'(bus.pend_o[1]), 0);

    // switch ch2 to level mode while high; level event beats clear
    bus.mode_i[5:4] = 2'b11;
    step(1);
    chk("t7_lvl", 32'(bus.pend_o[2]), 1);
    bus.clr_i[2] = 1'b1;
    step(1);
    bus.clr_i = '0;
    chk("t7_lvl_clr", 32'(bus.pend_o[2]), 1);

    // falling mode on ch3
    bus.mode_i[7:6] = 2'b01;
    bus.sync_in[3] = 1'b0;
    step(3);
    chk("t8_fall_early", 32'(bus.pend_o[3]), 0);
    step(1);
    chk("t8_fall", 32'(bus.pend_o[3]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- Multi-channel external-interrupt controller that sits directly downstream of the per-pin input synchronizers.
- Takes the already-synchronized `s_clk`-domain levels and runs each through a glitch filter and a mode-selectable edge/level detector.
- Latches detected events into software-clearable pending bits.
- Produces a masked, registered interrupt request plus the lowest-index active channel ID for the core.

Parameters:
- N_CH, 4, number of interrupt channels (1..32).
- FILT_CYCLES, 3, consecutive samples a new level must hold before the filtered level follows (>=1; 1 = single register stage).
- ID_W, $clog2(N_CH) (min 1), width of irq_id_o.

Ports:
- s_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  global enable; low freezes filter and detector state.
- sync_in  in  N_CH  synchronized input levels, one per channel.
- mode_i  in  2*N_CH  per-channel mode, bits [2k+1:2k]: 00 rising, 01 falling, 10 both edges, 11 level-high.
- mask_i  in  N_CH  per-channel interrupt enable (1 = enabled).
- clr_i  in  N_CH  per-channel pending-clear strobe, one cycle.
- pend_o  out  N_CH  pending bits (unmasked).
- irq_o  out  1  registered interrupt request.
- irq_id_o  out  ID_W  lowest index k with pend&mask set; 0 when none.
- ovf_o  out  N_CH  overflow flags (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge): counters, filt_lvl, filt_lvl_d, pend_o, irq_o, irq_id_o and ovf_o all go to 0. Reset overrides every other input.
- Filter, per channel:
  - cnt counts consecutive edges where sync_in != filt_lvl; any agreeing sample resets cnt to 0.
  - On the FILT_CYCLES-th consecutive differing sample, filt_lvl takes sync_in and cnt returns to 0.
  - Pulses shorter than FILT_CYCLES samples are discarded.
- Detector: filt_lvl_d is filt_lvl delayed one edge. Event is combinational from these two:
  - rise = filt_lvl & ~filt_lvl_d
  - fall = ~filt_lvl & filt_lvl_d
  - mode 10 = rise|fall
  - mode 11 = filt_lvl, i.e. an event every cycle while high
- Pending:
  - Sets at the edge after the event cycle.
  - Cleared at an edge where clr_i[k]=1.
  - If an event and a clear coincide, set wins; the event is never lost.
  - Mask does not gate pending.
- Latency (FILT_CYCLES=3): sync_in first sampled high at edge t, held → filt_lvl=1 after t+2 → pend after t+3 → irq_o after t+4.
- irq_o and irq_id_o are registered from the current pend&mask, one edge after pend.
- irq_id_o uses fixed priority, lowest index wins. It is 0 with irq_o=0 when nothing is active.
- en=0: cnt, filt_lvl and filt_lvl_d hold; no new events are generated. clr_i still clears, and irq_o/irq_id_o keep tracking pend&mask. Re-enabling does not fabricate an event unless filt_lvl and filt_lvl_d differ.
- A mode_i change takes effect on the next evaluation. It is not retroactive, and a switch to 11 while high yields an event next cycle.
- A channel already high at reset release produces a rise event after FILT_CYCLES samples, because filt_lvl resets to 0.

Optional Feature:
- EXT_IRQ_OVF_EN defined: ovf_o[k] sets at an edge where an event occurs while pend[k] is already 1 and clr_i[k]=0. It clears with clr_i[k]. If clear and overflow coincide, the clear wins and pend is re-set.
- Not defined: ovf_o is tied to 0 and no overflow logic is synthesized.

Decomposition:
- Shared package holds the mode encodings MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_LVL=2'b11.
- One sub-module is natural: ext_irq_chan (filter + detector + pending + ovf for one channel), instantiated N_CH times in a generate loop.
- The top level holds only the priority encoder and the irq_o/irq_id_o registers.

Test Plan:
- N_CH=4, FILT=3, mode0=00, mask=4'b0001. Assert sync_in[0] and hold → pend_o=0001 three edges later, irq_o=1 one edge after that, irq_id_o=0.
- Glitch on sync_in[1] lasting 2 cycles, mode1=10 → pend_o[1] stays 0 and cnt returns to 0.
- Set pend[2] and pend[3] with mask=1100 → irq_id_o=2. Pulse clr_i[2] → irq_id_o=3 one edge later. Clear 3 → irq_o=0.
- Pulse clr_i[0] on the same cycle as a new rise event on ch0 → pend_o[0] remains 1.
- en=0 while sync_in[0] toggles high for 10 cycles → no pending. Raise en with input still high → rise event after 3 samples.
- EXT_IRQ_OVF_EN: two rise events on ch1 with no clear → ovf_o[1]=1. clr_i[1] → ovf_o[1]=0 and pend_o[1]=0.
